// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and the round-robin search used by the four-way output arbiter.
package mux4_rr_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } rr_pick_t;

  // First set bit of mask, visiting last+1, last+2, ... modulo NREQ.
  function automatic rr_pick_t rr_next(input logic [NREQ-1:0] mask, input logic [1:0] last);
    rr_pick_t   pick;
    logic [1:0] cand;
    pick.found = 1'b0;
    pick.idx   = 2'd0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = last + 2'(i);
      if (!pick.found && mask[cand]) begin
        pick.found = 1'b1;
        pick.idx   = cand;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_word.sv
// Purely combinational 4:1 word multiplexer steered by the arbiter select.
module mux4_word #(
  parameter int DW = 8
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  output logic [DW-1:0] y
);

  // Select one of the four requester words.
  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready output channel among four producers,
// with a per-grant transfer limit that only bites while someone else is waiting.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [1:0]           sel,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  // Count value at which the transfer in flight is the MAX_HOLD-th of this grant.
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);

  state_t          state_r;
  logic [1:0]      last_r;
  logic [CW-1:0]   count_r;
  logic            xfer_s;
  logic            others_s;
  logic            release_s;
  rr_pick_t        idle_pick_s;
  rr_pick_t        rel_pick_s;

  mux4_word #(.DW(DW)) u_mux (
    .sel (sel),
    .d0  (din[0*DW +: DW]),
    .d1  (din[1*DW +: DW]),
    .d2  (din[2*DW +: DW]),
    .d3  (din[3*DW +: DW]),
    .y   (out_data)
  );

  assign out_valid   = busy & req[sel];
  assign xfer_s      = out_valid & out_ready;
  assign others_s    = |(req & ~gnt);
  assign idle_pick_s = rr_next(req, last_r);
  assign rel_pick_s  = rr_next(req & ~gnt, sel);

  // Owner gives up the channel when it stops requesting or uses up its quota while others wait.
  always_comb begin
    release_s = 1'b0;
    if (state_r == GRANT) begin
      if (!req[sel]) begin
        release_s = 1'b1;
      end else if (xfer_s && (count_r == HOLD_LAST) && others_s) begin
        release_s = 1'b1;
      end else begin
        release_s = 1'b0;
      end
    end else begin
      release_s = 1'b0;
    end
  end

  // Arbitration FSM: grant, hold count and last-owner pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      busy    <= 1'b0;
      count_r <= '0;
      last_r  <= 2'd3;
    end else begin
      case (state_r)
        IDLE: begin
          if (idle_pick_s.found) begin
            state_r <= GRANT;
            gnt     <= 4'b0001 << idle_pick_s.idx;
            sel     <= idle_pick_s.idx;
            busy    <= 1'b1;
            count_r <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (release_s) begin
            last_r  <= sel;
            count_r <= '0;
            if (rel_pick_s.found) begin
              gnt <= 4'b0001 << rel_pick_s.idx;
              sel <= rel_pick_s.idx;
            end else begin
              state_r <= IDLE;
              gnt     <= 4'b0000;
              busy    <= 1'b0;
            end
          end else if (xfer_s) begin
            // Quota used with nobody waiting: start a fresh quota for the same owner.
            if (count_r == HOLD_LAST) begin
              count_r <= '0;
            end else if (count_r != HOLD_MAX) begin
              count_r <= count_r + 1'b1;
            end else begin
              count_r <= count_r;
            end
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt     <= 4'b0000;
          sel     <= 2'd0;
          busy    <= 1'b0;
          count_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (MAX_HOLD 4 and 2) against a behavioural model.
module tb_mux4_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic        out_ready;

  logic        ov_a, ov_b, busy_a, busy_b;
  logic [7:0]  od_a, od_b;
  logic [1:0]  sel_a, sel_b;
  logic [3:0]  gnt_a, gnt_b;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;
  bit rec_en = 1'b0;
  int rec_q[$];

  // Model state per instance: owner (-1 = idle), select, last owner, hold count.
  int m_own[2];
  int m_sel[2];
  int m_last[2];
  int m_cnt[2];

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
    .out_valid(ov_a), .out_data(od_a), .sel(sel_a), .gnt(gnt_a), .busy(busy_a)
  );

  mux4_rr_arbiter #(.DW(8), .MAX_HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .req(req), .din(din), .out_ready(out_ready),
    .out_valid(ov_b), .out_data(od_b), .sel(sel_b), .gnt(gnt_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int pick(input logic [3:0] m, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (m[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int i);
    int own, s, l, c, mh, nxt;
    bit rel;
    own = m_own[i]; s = m_sel[i]; l = m_last[i]; c = m_cnt[i];
    mh  = (i == 0) ? 4 : 2;
    rel = 1'b0;
    if (own < 0) begin
      nxt = pick(req, l);
      if (nxt >= 0) begin own = nxt; s = nxt; c = 0; end
    end else begin
      if (!req[own]) rel = 1'b1;
      else if (out_ready) begin
        c = c + 1;
        if (c == mh) begin
          c = 0;
          if ((req & ~(4'b0001 << own)) != 4'b0000) rel = 1'b1;
        end
      end
      if (rel) begin
        l   = own;
        nxt = pick(req & ~(4'b0001 << own), own);
        c   = 0;
        if (nxt >= 0) begin own = nxt; s = nxt; end
        else own = -1;
      end
    end
    m_own[i] <= own; m_sel[i] <= s; m_last[i] <= l; m_cnt[i] <= c;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_own[i] <= -1; m_sel[i] <= 0; m_last[i] <= 3; m_cnt[i] <= 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp(input int i, input logic [3:0] g, input logic [1:0] s, input logic b,
                     input logic v, input logic [7:0] d);
    logic [3:0] eg;
    logic       eb;
    eb = (m_own[i] >= 0);
    eg = eb ? (4'b0001 << m_own[i]) : 4'b0000;
    check($sformatf("model_gnt%0d", i), g, eg);
    check($sformatf("model_sel%0d", i), s, m_sel[i]);
    check($sformatf("model_busy%0d", i), b, eb);
    check($sformatf("model_valid%0d", i), v, eb & req[m_sel[i]]);
    check($sformatf("model_data%0d", i), d, din[m_sel[i]*8 +: 8]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, gnt_a, sel_a, busy_a, ov_a, od_a);
      cmp(1, gnt_b, sel_b, busy_b, ov_b, od_b);
    end
  end

  always @(negedge clk) begin
    if (rec_en && ov_b && out_ready) rec_q.push_back(int'(sel_b));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rot[9];
    logic [3:0] vreq[8];
    logic       vrdy[8];
    exp_rot = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    vreq    = '{4'b1001, 4'b1001, 4'b0110, 4'b0000, 4'b0111, 4'b1111, 4'b0100, 4'b1011};
    vrdy    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; req = 4'b0000; din = 32'hD3A55C1E; out_ready = 1'b0; cmp_en = 1'b1;
    tick(); tick();
    check("rst_gnt", gnt_a, 4'b0000);
    check("rst_sel", sel_a, 2'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_valid", ov_a, 1'b0);
    rst = 1'b0;
    tick();

    req = 4'b1111; tick();
    check("first_gnt", gnt_a, 4'b0001);
    check("first_data", od_a, 8'h1E);
    req = 4'b1110; tick();
    check("pre_rst_gnt", gnt_a, 4'b0010);

    rst = 1'b1; #1;
    check("async_rst_gnt", gnt_a, 4'b0000);
    check("async_rst_sel", sel_a, 2'd0);
    check("async_rst_busy", busy_a, 1'b0);
    check("async_rst_valid", ov_a, 1'b0);
    tick();
    rst = 1'b0; req = 4'b1111; tick();
    check("post_rst_gnt", gnt_a, 4'b0001);

    req = 4'b0100; out_ready = 1'b1; tick();
    check("single_gnt", gnt_a, 4'b0100);
    check("single_sel", sel_a, 2'd2);
    check("single_valid", ov_a, 1'b1);
    check("single_data", od_a, 8'hA5);
    repeat (10) tick();
    check("single_hold_a", gnt_a, 4'b0100);
    check("single_hold_b", gnt_b, 4'b0100);

    req = 4'b0000; tick();
    check("drain_gnt", gnt_a, 4'b0000);
    check("drain_busy", busy_a, 1'b0);
    req = 4'b0101; tick();
    check("wrap_gnt", gnt_a, 4'b0001);

    out_ready = 1'b0; req = 4'b1010; tick();
    check("drop_to1_gnt", gnt_a, 4'b0010);
    req = 4'b1000; tick();
    check("early_drop_gnt", gnt_a, 4'b1000);
    check("early_drop_sel", sel_a, 2'd3);

    req = 4'b0011; tick();
    check("bp_start_gnt", gnt_a, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("bp_stall%0d_gnt", i), gnt_a, 4'b0001);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    check("bp_3xfer_gnt", gnt_a, 4'b0001);
    tick();
    check("bp_limit_gnt", gnt_a, 4'b0010);

    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b1111; out_ready = 1'b1; tick();
    check("rot_first_gnt", gnt_b, 4'b0001);
    rec_en = 1'b1;
    repeat (9) tick();
    rec_en = 1'b0;
    check("rot_count", rec_q.size(), 9);
    for (int i = 0; i < 9 && i < rec_q.size(); i++)
      check($sformatf("rot_owner%0d", i), rec_q[i], exp_rot[i]);
    check("rot_hold4_gnt", gnt_a, 4'b0100);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        req = vreq[i]; out_ready = vrdy[i]; din = $urandom;
        tick();
      end
    end

    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one DW-bit output channel between four requesters.
- Drives the 2-bit select of a 4:1 word mux and returns a one-hot grant to the requesters.
- Enforces fairness with a per-grant transfer limit.
- Sits between four producer ports and a single valid/ready consumer.

Parameters:
- DW, 8, data width of each requester word and of out_data.
- MAX_HOLD, 4, maximum accepted transfers per grant while another requester is waiting (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; held high while the requester has data.
- din  input  4*DW  packed requester data; requester k occupies din[k*DW +: DW].
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  out_data is valid.
- out_data  output  DW  data of the granted requester.
- sel  output  2  registered mux select, equal to the index of the current owner.
- gnt  output  4  registered one-hot grant; all zero when idle.
- busy  output  1  registered; high while a grant is held.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state=IDLE, gnt=0, sel=0, busy=0, hold count=0.
  - Last-owner pointer=3, so requester 0 has first priority.
  - out_valid=0 while rst is high.
- States: IDLE and GRANT.
- IDLE:
  - At a clock edge with req≠0, pick the first set bit searching last+1, last+2, … modulo 4.
  - Load gnt, sel and owner, set busy, clear count, go to GRANT.
  - Latency: req high at edge N gives gnt and sel valid after edge N.
  - No grant is possible in the cycle req first rises.
- GRANT:
  - Combinational outputs: out_valid = busy & req[sel]; out_data = din[sel].
  - out_data always reflects din[sel], even when out_valid=0.
  - A transfer is out_valid & out_ready at an edge; each transfer increments count.
  - count saturates; its width is clog2(MAX_HOLD+1).
- Release conditions, evaluated at each edge in GRANT:
  - (a) req[owner]=0, or
  - (b) a transfer completes with count+1 = MAX_HOLD and any other req bit is set.
- On release, at that same edge:
  - Re-arbitrate among the req bits excluding the owner, searching from owner+1; last = old owner.
  - If a winner exists, switch gnt and sel directly with zero idle cycles, and clear count.
  - Otherwise go to IDLE: gnt=0, busy=0.
- Hold limit reached, no other request:
  - Keep the grant and clear count.
  - The owner keeps streaming and may be preempted later.
- Backpressure:
  - While out_ready=0, count, gnt and sel do not change.
  - A release by (a) still happens when req[owner] drops.
- The owner dropping req at the same edge as the final MAX_HOLD transfer is a single release; the owner is not regranted at that edge.
- A newly arriving request is seen only at the next edge (no combinational req→gnt path).
- gnt is always one-hot or zero, and sel always equals the index of the set gnt bit.

Decomposition:
- Shared package holds:
  - requester count constant NREQ=4;
  - state enum {IDLE, GRANT};
  - the round-robin next-index function (mask, last) → index and found flag.
- One natural sub-module: mux4_word (parameter DW; sel[1:0], four DW inputs → one DW output, purely combinational).
- The arbiter FSM, counter and pointer stay in the top module.

Test Plan:
- Reset: assert rst mid-grant with gnt=0010 → gnt=0000, sel=0, busy=0 and out_valid=0 before the next clock edge. After release, req=1111 → gnt=0001 after one edge.
- Single requester: req=0100, din[2]=8'hA5, out_ready=1 → one edge later gnt=0100, sel=2, out_valid=1, out_data=8'hA5. Continuous transfers with the grant held, since no one else waits.
- Fair rotation: MAX_HOLD=2, req=1111, out_ready=1 constantly → owner sequence 0,0,1,1,2,2,3,3,0 over transfers. No idle cycle between owners.
- Early drop: owner 1, req[3] high, requester 1 drops req → at that edge gnt=1000, sel=3, count=0.
- Backpressure: owner 0, req=0011, out_ready=0 for 6 cycles → gnt stays 0001 and count stays unchanged. Then 4 ready cycles (MAX_HOLD=4) → gnt=0010.
- Drain to idle: sole owner 2 drops req with req=0000 → gnt=0000, busy=0. Then req=0101 → gnt=1000? No: gnt=0001, because search starts from 3 and wraps to 0.
